// File: rtl/l2_cache_sa_if.sv
// l2_cache_sa_if: bundles the L1-facing request/response signals and the
// memory-facing block transfer signals of the L2 cache.
//   slave  : the cache (receives L1 requests and memory responses)
//   master : the environment (L1 requester plus memory)
// BLK_W equals one cache line in bits (BLOCK_SIZE bytes).
interface l2_cache_sa_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32
);
    localparam int BLK_W = BLOCK_SIZE * 8;

    logic [ADDR_WIDTH-1:0] l1_cache_addr;
    logic [DATA_WIDTH-1:0] l1_cache_data_in;
    logic                  l1_cache_read;
    logic                  l1_cache_write;
    logic                  l1_cache_ready;
    logic                  l1_cache_hit;
    logic                  l1_block_valid;
    logic [BLK_W-1:0]      l1_block_data_out;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [BLK_W-1:0]      mem_wdata_block;
    logic [BLK_W-1:0]      mem_data_block;
    logic                  mem_ready;

    modport slave (
        input  l1_cache_addr, l1_cache_data_in, l1_cache_read, l1_cache_write,
               mem_data_block, mem_ready,
        output l1_cache_ready, l1_cache_hit, l1_block_valid, l1_block_data_out,
               mem_addr, mem_read, mem_write, mem_wdata_block
    );

    modport master (
        output l1_cache_addr, l1_cache_data_in, l1_cache_read, l1_cache_write,
               mem_data_block, mem_ready,
        input  l1_cache_ready, l1_cache_hit, l1_block_valid, l1_block_data_out,
               mem_addr, mem_read, mem_write, mem_wdata_block
    );
endinterface

// File: rtl/l2_cache_sa.sv
// l2_cache_sa: N-way set-associative, write-back, write-allocate L2 cache.
// Read hits return the whole line; write hits merge one word and mark the
// line dirty. Misses write back a dirty victim as a whole block, then refill.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (aborts any memory transaction,
//          invalidates all lines)
//   bus  - l2_cache_sa_if.slave: L1 request/response and memory block port
// Build option:
//   L2_LRU_EN defined   -> true-LRU replacement (per-way age counters)
//   L2_LRU_EN undefined -> per-set round-robin pointer
module l2_cache_sa #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 512,
    parameter int BLOCK_SIZE = 32,
    parameter int NUM_WAYS   = 4
) (
    input  logic          clk,
    input  logic          rst,
    l2_cache_sa_if.slave  bus
);
    localparam int WORDS_PER_BLOCK = BLOCK_SIZE / (DATA_WIDTH / 8);
    localparam int NUM_SETS        = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
    localparam int OFFSET_W        = $clog2(BLOCK_SIZE);
    localparam int INDEX_W         = $clog2(NUM_SETS);
    localparam int TAG_W           = ADDR_WIDTH - INDEX_W - OFFSET_W;
    localparam int BLK_W           = DATA_WIDTH * WORDS_PER_BLOCK;
    localparam int WAY_W           = $clog2(NUM_WAYS);
    localparam int BYTE_W          = $clog2(DATA_WIDTH / 8);
    localparam int WORD_W          = OFFSET_W - BYTE_W;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] idx_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [WAY_W-1:0]   way_t;
    typedef logic [BLK_W-1:0]   line_t;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t              state;
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    tag_t                tag_q   [NUM_SETS][NUM_WAYS];
    line_t               line_q  [NUM_SETS][NUM_WAYS];

`ifdef L2_LRU_EN
    typedef logic [NUM_WAYS-1:0][WAY_W-1:0] age_row_t;
    age_row_t age_q [NUM_SETS];

    // Touched way becomes youngest; only ways younger than it age by one,
    // so the ages of a set always remain a permutation of 0..NUM_WAYS-1.
    function automatic age_row_t lru_touch(age_row_t a, way_t k);
        age_row_t n;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (way_t'(w) == k)  n[w] = '0;
            else if (a[w] < a[k]) n[w] = a[w] + 1'b1;
            else                  n[w] = a[w];
        end
        return n;
    endfunction
`else
    way_t rr_q [NUM_SETS];
`endif

    function automatic line_t merge_word(line_t l, word_t w, logic [DATA_WIDTH-1:0] d);
        line_t n;
        n = l;
        n[w*DATA_WIDTH +: DATA_WIDTH] = d;
        return n;
    endfunction

    // Incoming request fields, decoded straight from the bus in IDLE.
    tag_t  in_tag;
    idx_t  in_idx;
    word_t in_word;
    logic  unused_byte_bits;

    assign in_tag           = bus.l1_cache_addr[ADDR_WIDTH-1 -: TAG_W];
    assign in_idx           = bus.l1_cache_addr[OFFSET_W +: INDEX_W];
    assign in_word          = bus.l1_cache_addr[BYTE_W +: WORD_W];
    assign unused_byte_bits = ^bus.l1_cache_addr[BYTE_W-1:0];

    // Latched request for the miss path.
    tag_t                  req_tag_q;
    idx_t                  req_idx_q;
    word_t                 req_word_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  req_write_q;
    way_t                  vict_q;
    logic                  vict_valid_q;

    logic hit;
    way_t hit_way;
    logic has_inv;
    way_t vict_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[in_idx][w] && tag_q[in_idx][w] == in_tag) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
        end
    end

    always_comb begin
        has_inv  = 1'b0;
        vict_way = '0;
        // Scan downwards so the last assignment leaves the lowest invalid way.
        for (int unsigned w = NUM_WAYS; w > 0; w--) begin
            if (!valid_q[in_idx][w-1]) begin
                has_inv  = 1'b1;
                vict_way = way_t'(w - 1);
            end
        end
        if (!has_inv) begin
`ifdef L2_LRU_EN
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (age_q[in_idx][w] == way_t'(NUM_WAYS - 1)) vict_way = way_t'(w);
            end
`else
            vict_way = rr_q[in_idx];
`endif
        end
    end

    always_comb begin
        bus.l1_cache_ready = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            bus.l1_cache_hit      <= 1'b0;
            bus.l1_block_valid    <= 1'b0;
            bus.l1_block_data_out <= '0;
            bus.mem_addr          <= '0;
            bus.mem_read          <= 1'b0;
            bus.mem_write         <= 1'b0;
            bus.mem_wdata_block   <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
`ifdef L2_LRU_EN
                for (int unsigned w = 0; w < NUM_WAYS; w++) age_q[s][w] <= way_t'(w);
`else
                rr_q[s] <= '0;
`endif
            end
        end else begin
            bus.l1_cache_hit   <= 1'b0;
            bus.l1_block_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.l1_cache_read || bus.l1_cache_write) begin
                        if (hit) begin
                            bus.l1_cache_hit <= 1'b1;
                            if (bus.l1_cache_write) begin
                                line_q[in_idx][hit_way]  <= merge_word(line_q[in_idx][hit_way],
                                                                       in_word, bus.l1_cache_data_in);
                                dirty_q[in_idx][hit_way] <= 1'b1;
                            end else begin
                                bus.l1_block_data_out <= line_q[in_idx][hit_way];
                                bus.l1_block_valid    <= 1'b1;
                            end
`ifdef L2_LRU_EN
                            age_q[in_idx] <= lru_touch(age_q[in_idx], hit_way);
`endif
                        end else begin
                            req_tag_q    <= in_tag;
                            req_idx_q    <= in_idx;
                            req_word_q   <= in_word;
                            req_wdata_q  <= bus.l1_cache_data_in;
                            req_write_q  <= bus.l1_cache_write;
                            vict_q       <= vict_way;
                            vict_valid_q <= !has_inv;
                            if (valid_q[in_idx][vict_way] && dirty_q[in_idx][vict_way]) begin
                                bus.mem_addr        <= {tag_q[in_idx][vict_way], in_idx, {OFFSET_W{1'b0}}};
                                bus.mem_wdata_block <= line_q[in_idx][vict_way];
                                bus.mem_write       <= 1'b1;
                                state               <= WRITEBACK;
                            end else begin
                                bus.mem_addr <= {in_tag, in_idx, {OFFSET_W{1'b0}}};
                                bus.mem_read <= 1'b1;
                                state        <= FILL;
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        bus.mem_write <= 1'b0;
                        bus.mem_read  <= 1'b1;
                        bus.mem_addr  <= {req_tag_q, req_idx_q, {OFFSET_W{1'b0}}};
                        state         <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        bus.mem_read               <= 1'b0;
                        valid_q[req_idx_q][vict_q] <= 1'b1;
                        tag_q[req_idx_q][vict_q]   <= req_tag_q;
                        if (req_write_q) begin
                            line_q[req_idx_q][vict_q]  <= merge_word(bus.mem_data_block,
                                                                     req_word_q, req_wdata_q);
                            dirty_q[req_idx_q][vict_q] <= 1'b1;
                        end else begin
                            line_q[req_idx_q][vict_q]  <= bus.mem_data_block;
                            dirty_q[req_idx_q][vict_q] <= 1'b0;
                            bus.l1_block_data_out      <= bus.mem_data_block;
                            bus.l1_block_valid         <= 1'b1;
                        end
`ifdef L2_LRU_EN
                        age_q[req_idx_q] <= lru_touch(age_q[req_idx_q], vict_q);
`else
                        if (vict_valid_q) rr_q[req_idx_q] <= rr_q[req_idx_q] + 1'b1;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache_sa.sv
// tb_l2_cache_sa: randomized self-checking bench for l2_cache_sa.
// A reference model keeps each set as a list of blocks with a recency order
// (or a round-robin pointer when L2_LRU_EN is undefined) and predicts hits,
// victims, writebacks and returned data. The memory responder serves block b
// word w = (b<<8)|w and acknowledges after a configurable number of waits.
module tb_l2_cache_sa;
    localparam int DW = 32, AW = 11, BS = 32, CS = 512, NW = 4;
    localparam int NS = 4, WPB = 8, NBLK = 64, BW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_cache_sa_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) bus ();

    l2_cache_sa #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CACHE_SIZE(CS), .BLOCK_SIZE(BS), .NUM_WAYS(NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            valid;
        bit            dirty;
        int unsigned   blk;
        logic [BW-1:0] data;
    } mline_t;

    mline_t        m     [NS][NW];
    int unsigned   order [NS][NW];   // most recent first
    int unsigned   rr    [NS];
    logic [BW-1:0] ref_mem [NBLK];
    logic [BW-1:0] env_mem [NBLK];

    function automatic logic [BW-1:0] init_block(int unsigned b);
        logic [BW-1:0] l;
        for (int unsigned w = 0; w < WPB; w++) l[w*DW +: DW] = DW'((b << 8) | w);
        return l;
    endfunction

    task automatic model_reset();
        for (int unsigned s = 0; s < NS; s++) begin
            rr[s] = 0;
            for (int unsigned w = 0; w < NW; w++) begin
                m[s][w].valid = 1'b0;
                m[s][w].dirty = 1'b0;
                order[s][w]   = w;
            end
        end
    endtask

    task automatic touch(input int unsigned s, input int unsigned k);
        int unsigned p = 0;
        for (int unsigned i = 0; i < NW; i++) if (order[s][i] == k) p = i;
        for (int unsigned i = p; i > 0; i--) order[s][i] = order[s][i-1];
        order[s][0] = k;
    endtask

    function automatic int unsigned pick_victim(int unsigned s);
        for (int unsigned w = 0; w < NW; w++) if (!m[s][w].valid) return w;
`ifdef L2_LRU_EN
        return order[s][NW-1];
`else
        return rr[s];
`endif
    endfunction

    // ---------------- memory responder ----------------
    int unsigned     stall = 0;
    int unsigned     wait_cnt = 0;
    logic [AW-1:0]   wb_addr_q [$];
    logic [BW-1:0]   wb_data_q [$];
    logic [AW-1:0]   rd_addr_q [$];

    initial begin
        bus.mem_ready      = 1'b0;
        bus.mem_data_block = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.mem_ready = 1'b0;
                wait_cnt      = 0;
            end else if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (bus.mem_read || bus.mem_write) begin
                if (wait_cnt < stall) begin
                    wait_cnt++;
                end else begin
                    wait_cnt      = 0;
                    bus.mem_ready = 1'b1;
                    if (bus.mem_write) begin
                        wb_addr_q.push_back(bus.mem_addr);
                        wb_data_q.push_back(bus.mem_wdata_block);
                        env_mem[bus.mem_addr[10:5]] = bus.mem_wdata_block;
                    end else begin
                        rd_addr_q.push_back(bus.mem_addr);
                        bus.mem_data_block = env_mem[bus.mem_addr[10:5]];
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- one L1 access, fully checked ----------------
    task automatic access(input logic [AW-1:0] addr, input bit rd, input bit wr,
                          input logic [DW-1:0] wd, input bit poke);
        int unsigned   b, s, wi, v, nwb0, nrd0, cyc;
        int            hw;
        bit            exp_wb, done, repl_valid;
        logic [AW-1:0] wb_a, fill_a;
        logic [BW-1:0] wb_d, line;

        b  = addr[10:5];
        s  = b % NS;
        wi = addr[4:2];
        hw = -1;
        for (int unsigned w = 0; w < NW; w++)
            if (m[s][w].valid && m[s][w].blk == b) hw = int'(w);

        @(negedge clk);
        bus.l1_cache_addr    = addr;
        bus.l1_cache_data_in = wd;
        bus.l1_cache_read    = rd;
        bus.l1_cache_write   = wr;
        nwb0 = wb_addr_q.size();
        nrd0 = rd_addr_q.size();
        @(posedge clk);
        #1;
        bus.l1_cache_read  = 1'b0;
        bus.l1_cache_write = 1'b0;

        if (!rd && !wr) begin
            check_eq("idle_hit", bus.l1_cache_hit, 0);
            check_eq("idle_valid", bus.l1_block_valid, 0);
            check_eq("idle_ready", bus.l1_cache_ready, 1);
        end else if (hw >= 0) begin
            check_eq("hit_pulse", bus.l1_cache_hit, 1);
            check_eq("hit_valid", bus.l1_block_valid, !wr);
            check_eq("hit_ready", bus.l1_cache_ready, 1);
            if (!wr) check_eq("hit_data", bus.l1_block_data_out, m[s][hw].data);
            else begin
                m[s][hw].data[wi*DW +: DW] = wd;
                m[s][hw].dirty = 1'b1;
            end
            touch(s, hw);
        end else begin
            v      = pick_victim(s);
            exp_wb = m[s][v].valid && m[s][v].dirty;
            wb_a   = AW'(m[s][v].blk << 5);
            wb_d   = m[s][v].data;
            fill_a = AW'(b << 5);
            check_eq("miss_hit", bus.l1_cache_hit, 0);
            check_eq("miss_valid", bus.l1_block_valid, 0);
            check_eq("miss_ready", bus.l1_cache_ready, 0);
            check_eq("miss_mem_write", bus.mem_write, exp_wb);
            check_eq("miss_mem_read", bus.mem_read, !exp_wb);
            check_eq("miss_mem_addr", bus.mem_addr, exp_wb ? wb_a : fill_a);
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 100) begin
                if (poke) begin
                    bus.l1_cache_read = 1'b1;
                    bus.l1_cache_addr = addr;
                end
                @(posedge clk);
                #1;
                cyc++;
                if (bus.l1_cache_ready) done = 1'b1;
                else begin
                    check_eq("busy_one_req", bus.mem_read ^ bus.mem_write, 1);
                    check_eq("busy_addr", bus.mem_addr, bus.mem_write ? wb_a : fill_a);
                    check_eq("busy_hit", bus.l1_cache_hit, 0);
                end
            end
            bus.l1_cache_read = 1'b0;
            check_eq("miss_complete", done, 1);
            check_eq("fill_hit", bus.l1_cache_hit, 0);
            check_eq("fill_valid", bus.l1_block_valid, !wr);
            check_eq("fill_mem_idle", {bus.mem_read, bus.mem_write}, 0);
            check_eq("wb_count", wb_addr_q.size() - nwb0, exp_wb);
            if (exp_wb && wb_addr_q.size() > nwb0) begin
                check_eq("wb_addr", wb_addr_q[nwb0], wb_a);
                check_eq("wb_data", wb_data_q[nwb0], wb_d);
                ref_mem[m[s][v].blk] = wb_d;
            end
            check_eq("rd_count", rd_addr_q.size() - nrd0, 1);
            if (rd_addr_q.size() > nrd0) check_eq("rd_addr", rd_addr_q[nrd0], fill_a);
            line = ref_mem[b];
            if (!wr) check_eq("fill_data", bus.l1_block_data_out, line);
            else line[wi*DW +: DW] = wd;
            repl_valid = m[s][v].valid;
            m[s][v].valid = 1'b1;
            m[s][v].dirty = wr;
            m[s][v].blk   = b;
            m[s][v].data  = line;
            touch(s, v);
            if (repl_valid) rr[s] = (rr[s] + 1) % NW;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned   nwb0, op;
        logic [AW-1:0] ra;

        bus.l1_cache_addr    = '0;
        bus.l1_cache_data_in = '0;
        bus.l1_cache_read    = 1'b0;
        bus.l1_cache_write   = 1'b0;
        for (int unsigned b = 0; b < NBLK; b++) begin
            ref_mem[b] = init_block(b);
            env_mem[b] = init_block(b);
        end
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", bus.l1_cache_ready, 1);
        check_eq("rst_hit", bus.l1_cache_hit, 0);
        check_eq("rst_valid", bus.l1_block_valid, 0);
        check_eq("rst_mem_rw", {bus.mem_read, bus.mem_write}, 0);
        check_eq("rst_data_out", bus.l1_block_data_out, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_wdata", bus.mem_wdata_block, 0);
        @(negedge clk);
        rst = 1'b0;

        // Cold read, re-read hit, write hit, read-back.
        access(11'h06C, 1, 0, 0, 0);
        access(11'h074, 1, 0, 0, 0);
        access(11'h068, 0, 1, 32'hDEADBEEF, 0);
        access(11'h060, 1, 0, 0, 0);
        check_eq("deadbeef_word", bus.l1_block_data_out[95:64], 32'hDEADBEEF);
        check_eq("word0_kept", bus.l1_block_data_out[31:0], 32'h0300);

        // Fill the rest of set 3, re-touch block 3, then force a replacement.
        access(11'h0E0, 1, 0, 0, 0);
        access(11'h160, 1, 0, 0, 0);
        access(11'h1E0, 1, 0, 0, 0);
        access(11'h060, 1, 0, 0, 0);
        nwb0 = wb_addr_q.size();
        access(11'h260, 1, 0, 0, 0);
`ifdef L2_LRU_EN
        check_eq("b19_no_wb", wb_addr_q.size() - nwb0, 0);
`else
        check_eq("b19_wb", wb_addr_q.size() - nwb0, 1);
        if (wb_addr_q.size() > nwb0) begin
            check_eq("b19_wb_addr", wb_addr_q[nwb0], 11'h060);
            check_eq("b19_wb_word2", wb_data_q[nwb0][95:64], 32'hDEADBEEF);
        end
`endif
        check_eq("b19_rd_addr", rd_addr_q[rd_addr_q.size()-1], 11'h260);

        // Slow memory with a read asserted while busy.
        stall = 5;
        access(11'h0A4, 1, 0, 0, 1);
        stall = 0;

        // Reset in the middle of a fill.
        stall = 1000;
        @(negedge clk);
        bus.l1_cache_addr = 11'h400;
        bus.l1_cache_read = 1'b1;
        @(posedge clk);
        #1;
        bus.l1_cache_read = 1'b0;
        check_eq("abort_pre_read", bus.mem_read, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_mem_read", bus.mem_read, 0);
        check_eq("abort_ready", bus.l1_cache_ready, 1);
        @(negedge clk);
        rst   = 1'b0;
        stall = 0;
        model_reset();
        access(11'h074, 1, 0, 0, 0);
        access(11'h400, 1, 0, 0, 0);

        // Randomized traffic over 8 blocks per set.
        for (int unsigned i = 0; i < 400; i++) begin
            ra    = AW'(($urandom_range(0, 31) << 5) | $urandom_range(0, 31));
            op    = $urandom_range(0, 7);
            stall = $urandom_range(0, 2);
            access(ra, op == 1 || op >= 5, op >= 1 && op <= 4, $urandom, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
